// File: rtl/arith_pkg.sv
// Shared constants, encodings and types for the multi-cycle arithmetic machine.
package arith_pkg;

    localparam int unsigned INST_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned IMM_W    = 16;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    typedef enum logic [2:0] {
        ALU_ADDU = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_NOR  = 3'd5,
        ALU_XOR  = 3'd6,
        ALU_LUI  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_SIGN = 2'd0,
        IMM_ZERO = 2'd1,
        IMM_LUI  = 2'd2
    } imm_mode_e;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_EXCEPT    = 3'd4
    } state_e;

    typedef struct packed {
        alu_op_e           alu_op;
        imm_mode_e         imm_mode;
        logic              use_imm;
        logic [REG_AW-1:0] dest;
        logic              trap_en;
        logic              illegal;
    } decode_t;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(4);
    endfunction

endpackage

// File: rtl/arith_decode_mc.sv
// Combinational instruction decode: ALU op, immediate form, destination and trap/illegal flags.
module arith_decode_mc
    import arith_pkg::*;
(
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    output decode_t           dec_c
);

    always_comb begin
        dec_c          = '0;
        dec_c.alu_op   = ALU_ADDU;
        dec_c.imm_mode = IMM_SIGN;
        dec_c.dest     = rt;
        case (opcode)
            OP_RTYPE: begin
                dec_c.dest = rd;
                case (funct)
                    FN_ADD: begin
                        dec_c.alu_op  = ALU_ADD;
                        dec_c.trap_en = 1'b1;
                    end
                    FN_ADDU: dec_c.alu_op = ALU_ADDU;
                    FN_SUB: begin
                        dec_c.alu_op  = ALU_SUB;
                        dec_c.trap_en = 1'b1;
                    end
                    FN_AND:  dec_c.alu_op = ALU_AND;
                    FN_OR:   dec_c.alu_op = ALU_OR;
                    FN_XOR:  dec_c.alu_op = ALU_XOR;
                    FN_NOR:  dec_c.alu_op = ALU_NOR;
                    default: dec_c.illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec_c.alu_op  = ALU_ADD;
                dec_c.use_imm = 1'b1;
                dec_c.trap_en = 1'b1;
            end
            OP_ADDIU: begin
                dec_c.alu_op  = ALU_ADDU;
                dec_c.use_imm = 1'b1;
            end
            OP_ANDI: begin
                dec_c.alu_op   = ALU_AND;
                dec_c.use_imm  = 1'b1;
                dec_c.imm_mode = IMM_ZERO;
            end
            OP_ORI: begin
                dec_c.alu_op   = ALU_OR;
                dec_c.use_imm  = 1'b1;
                dec_c.imm_mode = IMM_ZERO;
            end
            OP_XORI: begin
                dec_c.alu_op   = ALU_XOR;
                dec_c.use_imm  = 1'b1;
                dec_c.imm_mode = IMM_ZERO;
            end
            OP_LUI: begin
                dec_c.alu_op   = ALU_LUI;
                dec_c.use_imm  = 1'b1;
                dec_c.imm_mode = IMM_LUI;
            end
            default: dec_c.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/arith_machine_mc.sv
// Multi-cycle MIPS arithmetic machine: handshake fetch, decode, execute, writeback,
// sticky exception with EPC, and a retired-instruction counter.
module arith_machine_mc
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [INST_W-1:0] imem_data,
    output logic              except,
    output logic [ADDR_W-1:0] epc,
    output logic              retired,
    output logic [CNT_W-1:0]  inst_count
);

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] ir;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  res;
    logic [WIDTH-1:0]  rf [NUM_REGS];

    logic              req_nxt;
    logic              except_nxt;
    logic [ADDR_W-1:0] epc_nxt;
    logic              retired_nxt;

    decode_t           dec_c;
    logic [IMM_W-1:0]  imm16;
    logic [WIDTH-1:0]  imm_c;
    logic [WIDTH-1:0]  sum_c;
    logic [WIDTH-1:0]  diff_c;
    logic [WIDTH-1:0]  alu_c;
    logic              ovf_c;
    logic              fetch_ok;

    assign imem_addr = pc;
    assign imm16     = ir[IMM_W-1:0];
    assign fetch_ok  = imem_req && imem_valid;

    arith_decode_mc u_decode (
        .opcode (ir[31:26]),
        .funct  (ir[5:0]),
        .rt     (ir[20:16]),
        .rd     (ir[15:11]),
        .dec_c  (dec_c)
    );

    // Immediate formation; lui zero-fills everything above bit 31
    always_comb begin
        imm_c = '0;
        case (dec_c.imm_mode)
            IMM_SIGN: imm_c = WIDTH'($signed(imm16));
            IMM_ZERO: imm_c = WIDTH'(imm16);
            IMM_LUI:  imm_c = WIDTH'({imm16, 16'h0000});
            default:  imm_c = '0;
        endcase
    end

    // ALU and signed-overflow detection at WIDTH bits
    always_comb begin
        sum_c  = op_a + op_b;
        diff_c = op_a - op_b;
        alu_c  = sum_c;
        ovf_c  = 1'b0;
        case (dec_c.alu_op)
            ALU_ADDU: alu_c = sum_c;
            ALU_ADD: begin
                alu_c = sum_c;
                ovf_c = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_c[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_c = diff_c;
                ovf_c = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff_c[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_AND: alu_c = op_a & op_b;
            ALU_OR:  alu_c = op_a | op_b;
            ALU_NOR: alu_c = ~(op_a | op_b);
            ALU_XOR: alu_c = op_a ^ op_b;
            ALU_LUI: alu_c = op_b;
            default: alu_c = sum_c;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus next values of the registered control outputs
    always_comb begin
        state_nxt   = state;
        except_nxt  = except;
        epc_nxt     = epc;
        req_nxt     = 1'b0;
        retired_nxt = 1'b0;
        case (state)
            S_FETCH: begin
                if (fetch_ok) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_c.illegal) begin
                    state_nxt  = S_EXCEPT;
                    except_nxt = 1'b1;
                    epc_nxt    = pc;
                end else begin
                    state_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (dec_c.trap_en && ovf_c) begin
                    state_nxt  = S_EXCEPT;
                    except_nxt = 1'b1;
                    epc_nxt    = pc;
                end else begin
                    state_nxt = S_WRITEBACK;
                end
            end
            S_WRITEBACK: state_nxt = S_FETCH;
            S_EXCEPT:    state_nxt = S_EXCEPT;
            default:     state_nxt = S_FETCH;
        endcase
        req_nxt     = (state_nxt == S_FETCH);
        retired_nxt = (state_nxt == S_WRITEBACK);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            imem_req <= 1'b0;
            except   <= 1'b0;
            epc      <= '0;
            retired  <= 1'b0;
        end else begin
            imem_req <= req_nxt;
            except   <= except_nxt;
            epc      <= epc_nxt;
            retired  <= retired_nxt;
        end
    end

    // Datapath registers and register file; r0 is never written so it reads as zero
    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= '0;
            ir         <= '0;
            op_a       <= '0;
            op_b       <= '0;
            res        <= '0;
            inst_count <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (fetch_ok) begin
                        ir <= imem_data;
                    end
                end
                S_DECODE: begin
                    op_a <= rf[ir[25:21]];
                    op_b <= dec_c.use_imm ? imm_c : rf[ir[20:16]];
                end
                S_EXECUTE: res <= alu_c;
                S_WRITEBACK: begin
                    if (dec_c.dest != '0) begin
                        rf[dec_c.dest] <= res;
                    end
                    pc         <= next_pc(pc);
                    inst_count <= inst_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_machine_mc.sv
// Directed self-checking bench for arith_machine_mc (32-bit instance plus a 64-bit trap run).
module tb_arith_machine_mc;

    logic        clock;
    logic        reset;
    logic        reset64;

    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] data;
    logic        exc;
    logic [31:0] epc;
    logic        retired;
    logic [31:0] count;

    logic        req64;
    logic [31:0] addr64;
    logic        valid64;
    logic [31:0] data64;
    logic        exc64;
    logic [31:0] epc64;
    logic        retired64;
    logic [31:0] count64;

    logic [31:0] mem32  [128];
    logic [3:0]  wait32 [128];
    logic [31:0] mem64  [128];
    logic [3:0]  wcnt;

    int checks   = 0;
    int failures = 0;

    arith_machine_mc #(.WIDTH(32), .CNT_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_req   (req),
        .imem_addr  (addr),
        .imem_valid (valid),
        .imem_data  (data),
        .except     (exc),
        .epc        (epc),
        .retired    (retired),
        .inst_count (count)
    );

    arith_machine_mc #(.WIDTH(64), .CNT_W(32)) dut64 (
        .clock      (clock),
        .reset      (reset64),
        .imem_req   (req64),
        .imem_addr  (addr64),
        .imem_valid (valid64),
        .imem_data  (data64),
        .except     (exc64),
        .epc        (epc64),
        .retired    (retired64),
        .inst_count (count64)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory models: per-word wait count for the 32-bit DUT, zero-wait for 64-bit
    assign valid   = req && (wcnt == wait32[7'(addr >> 2)]);
    assign data    = mem32[7'(addr >> 2)];
    assign valid64 = req64;
    assign data64  = mem64[7'(addr64 >> 2)];

    always_ff @(posedge clock) begin
        if (!req || valid) wcnt <= 4'd0;
        else               wcnt <= wcnt + 4'd1;
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) begin
            mem32[i]  = 32'h0000_0025;
            wait32[i] = 4'd0;
        end
    endtask

    task automatic start(input string tag);
        reset = 1'b1;
        step(2);
        chk({tag, "_rst_req"},     64'(req),     64'd0);
        chk({tag, "_rst_addr"},    64'(addr),    64'd0);
        chk({tag, "_rst_except"},  64'(exc),     64'd0);
        chk({tag, "_rst_epc"},     64'(epc),     64'd0);
        chk({tag, "_rst_retired"}, 64'(retired), 64'd0);
        chk({tag, "_rst_count"},   64'(count),   64'd0);
        reset = 1'b0;
    endtask

    logic [9:0]  pat10;
    logic [11:0] pat12;
    logic        any_ret;
    int          hit_k;

    initial begin
        reset   = 1'b1;
        reset64 = 1'b1;
        for (int i = 0; i < 128; i++) mem64[i] = 32'h0000_0025;
        mem64[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd1);
        mem64[1] = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF);
        for (int i = 2; i <= 64; i++) mem64[i] = enc_r(6'h20, 5'd1, 5'd1, 5'd1);
        mem64[65] = enc_r(6'h22, 5'd1, 5'd3, 5'd2);

        // Zero-wait fetch: addi r1,r0,5 ; addi r2,r1,-7
        clear_mem();
        mem32[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem32[1] = enc_i(6'h08, 5'd1, 5'd2, 16'hFFF9);
        start("s1");
        for (int k = 1; k <= 10; k++) begin
            step(1);
            pat10[k-1] = retired;
            if (k == 1) begin
                chk("s1_req_k1", 64'(req), 64'd1);
                chk("s1_addr_k1", 64'(addr), 64'd0);
            end
            if (k == 5) chk("s1_addr_k5", 64'(addr), 64'd4);
        end
        chk("s1_retired_pattern", 64'(pat10), 64'h088);
        chk("s1_count", 64'(count), 64'd2);
        chk("s1_r1", 64'(dut.rf[1]), 64'd5);
        chk("s1_r2", 64'(dut.rf[2]), 64'hFFFF_FFFE);

        // Three wait cycles on the second fetch
        wait32[1] = 4'd3;
        start("s2");
        for (int k = 1; k <= 12; k++) begin
            step(1);
            pat12[k-1] = retired;
            if (k >= 5 && k <= 8) begin
                chk($sformatf("s2_req_k%0d", k), 64'(req), 64'd1);
                chk($sformatf("s2_addr_k%0d", k), 64'(addr), 64'd4);
            end
        end
        chk("s2_retired_pattern", 64'(pat12), 64'h408);
        chk("s2_count", 64'(count), 64'd2);
        chk("s2_r2", 64'(dut.rf[2]), 64'hFFFF_FFFE);

        // Signed overflow: addu wraps silently, add traps
        clear_mem();
        mem32[0] = enc_i(6'h0f, 5'd0, 5'd1, 16'h7FFF);
        mem32[1] = enc_i(6'h0d, 5'd1, 5'd1, 16'hFFFF);
        mem32[2] = enc_r(6'h21, 5'd1, 5'd1, 5'd3);
        mem32[3] = enc_r(6'h20, 5'd1, 5'd1, 5'd3);
        start("s3");
        step(15);
        chk("s3_except_k15", 64'(exc), 64'd0);
        step(1);
        chk("s3_except_k16", 64'(exc), 64'd1);
        chk("s3_epc", 64'(epc), 64'd12);
        chk("s3_req", 64'(req), 64'd0);
        chk("s3_count", 64'(count), 64'd3);
        any_ret = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            any_ret = any_ret | retired;
        end
        chk("s3_no_retire", 64'(any_ret), 64'd0);
        chk("s3_req_held", 64'(req), 64'd0);
        chk("s3_except_sticky", 64'(exc), 64'd1);
        chk("s3_r1", 64'(dut.rf[1]), 64'h7FFF_FFFF);
        chk("s3_r3", 64'(dut.rf[3]), 64'hFFFF_FFFE);

        // Logical / immediate forms
        clear_mem();
        mem32[0] = enc_i(6'h0f, 5'd0, 5'd4, 16'h1234);
        mem32[1] = enc_i(6'h0d, 5'd4, 5'd4, 16'hABCD);
        mem32[2] = enc_i(6'h0e, 5'd4, 5'd5, 16'hFFFF);
        mem32[3] = enc_i(6'h0c, 5'd4, 5'd6, 16'h0F0F);
        mem32[4] = enc_i(6'h09, 5'd0, 5'd7, 16'hFFFF);
        mem32[5] = enc_r(6'h22, 5'd4, 5'd5, 5'd8);
        mem32[6] = enc_r(6'h27, 5'd0, 5'd0, 5'd9);
        mem32[7] = enc_r(6'h24, 5'd4, 5'd5, 5'd10);
        mem32[8] = enc_r(6'h26, 5'd4, 5'd5, 5'd11);
        mem32[9] = enc_i(6'h09, 5'd7, 5'd12, 16'd1);
        start("s4");
        step(42);
        chk("s4_r4_lui_ori", 64'(dut.rf[4]), 64'h1234_ABCD);
        chk("s4_r5_xori", 64'(dut.rf[5]), 64'h1234_5432);
        chk("s4_r6_andi", 64'(dut.rf[6]), 64'h0000_0B0D);
        chk("s4_r7_addiu", 64'(dut.rf[7]), 64'hFFFF_FFFF);
        chk("s4_r8_sub", 64'(dut.rf[8]), 64'h0000_579B);
        chk("s4_r9_nor", 64'(dut.rf[9]), 64'hFFFF_FFFF);
        chk("s4_r10_and", 64'(dut.rf[10]), 64'h1234_0000);
        chk("s4_r11_xor", 64'(dut.rf[11]), 64'h0000_FFFF);
        chk("s4_r12_addiu_wrap", 64'(dut.rf[12]), 64'd0);
        chk("s4_count", 64'(count), 64'd10);
        chk("s4_no_except", 64'(exc), 64'd0);

        // Illegal opcode after a discarded write to r0
        clear_mem();
        mem32[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
        mem32[1] = enc_i(6'h23, 5'd0, 5'd1, 16'd0);
        start("s5");
        step(6);
        chk("s5_except_k6", 64'(exc), 64'd0);
        step(1);
        chk("s5_except_k7", 64'(exc), 64'd1);
        chk("s5_epc", 64'(epc), 64'd4);
        chk("s5_req_k7", 64'(req), 64'd0);
        step(5);
        chk("s5_req_later", 64'(req), 64'd0);
        chk("s5_r0", 64'(dut.rf[0]), 64'd0);
        chk("s5_count", 64'(count), 64'd1);

        // Reset during EXECUTE of a write to r6
        clear_mem();
        mem32[0] = enc_i(6'h08, 5'd0, 5'd6, 16'd1);
        mem32[1] = enc_i(6'h08, 5'd0, 5'd6, 16'h0055);
        start("s6");
        step(5);
        chk("s6_r6_before", 64'(dut.rf[6]), 64'd1);
        chk("s6_count_before", 64'(count), 64'd1);
        step(2);
        reset = 1'b1;
        step(1);
        chk("s6_req", 64'(req), 64'd0);
        chk("s6_addr", 64'(addr), 64'd0);
        chk("s6_count", 64'(count), 64'd0);
        chk("s6_except", 64'(exc), 64'd0);
        chk("s6_retired", 64'(retired), 64'd0);
        chk("s6_r6", 64'(dut.rf[6]), 64'd0);
        reset = 1'b0;
        step(1);
        chk("s6_refetch_req", 64'(req), 64'd1);
        chk("s6_refetch_addr", 64'(addr), 64'd0);

        // WIDTH=64: build -2^63 by doubling -1, then sub 1 traps
        reset64 = 1'b0;
        hit_k = 0;
        for (int k = 1; k <= 400 && hit_k == 0; k++) begin
            step(1);
            if (exc64) hit_k = k;
        end
        chk("s7_except64", 64'(exc64), 64'd1);
        chk("s7_trap_cycle", 64'(hit_k), 64'd264);
        chk("s7_epc64", 64'(epc64), 64'd260);
        chk("s7_count64", 64'(count64), 64'd65);
        chk("s7_r1_min", dut64.rf[1], 64'h8000_0000_0000_0000);
        chk("s7_r2_untouched", dut64.rf[2], 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
